// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter merging the I-cache and D-cache 128-bit
// block ports onto one shared memory port.
//
// Ports
//   clk, proc_reset_n            system clock, synchronous active-low reset
//   ic_read/ic_write/ic_addr/ic_wdata  I-cache request (held until ic_ready)
//   ic_rdata, ic_ready           I-cache response (rdata valid with ready)
//   dc_read/dc_write/dc_addr/dc_wdata  D-cache request (held until dc_ready)
//   dc_rdata, dc_ready           D-cache response (rdata valid with ready)
//   mem_read/mem_write/mem_addr/mem_wdata  shared memory request
//   mem_rdata, mem_ready         shared memory response
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; pick a requester (round-robin on collision)
// GNT_I | I-cache owns memory; latched request driven until mem_ready
// GNT_D | D-cache owns memory; latched request driven until mem_ready
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,

    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,

    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;   // 0 = I, 1 = D
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic                req_we_q, req_we_d;

    logic                ic_req;
    logic                dc_req;
    logic                pick_d;

    assign ic_req = ic_read | ic_write;
    assign dc_req = dc_read | dc_write;

    // D wins when it is the only requester, or on a collision when I was
    // served last (last_gnt resets to I, so D wins the first collision).
    assign pick_d = dc_req & (~ic_req | ~last_gnt_q);

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_we_q    <= req_we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_we_d    = req_we_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ic_ready    = 1'b0;
        dc_ready    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = GNT_D;
                    last_gnt_d  = 1'b1;
                    req_addr_d  = dc_addr;
                    req_wdata_d = dc_wdata;
                    req_we_d    = dc_write;
                end else if (ic_req) begin
                    state_d     = GNT_I;
                    last_gnt_d  = 1'b0;
                    req_addr_d  = ic_addr;
                    req_wdata_d = ic_wdata;
                    req_we_d    = ic_write;
                end
            end
            GNT_I: begin
                // Strobes drop in the completion cycle so memory never sees
                // a second back-to-back request from the same grant.
                mem_read  = ~req_we_q & ~mem_ready;
                mem_write =  req_we_q & ~mem_ready;
                ic_ready  = mem_ready;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                mem_read  = ~req_we_q & ~mem_ready;
                mem_write =  req_we_q & ~mem_ready;
                dc_ready  = mem_ready;
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr  = req_addr_q;
    assign mem_wdata = req_wdata_q;
    assign ic_rdata  = mem_rdata;
    assign dc_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          proc_reset_n;
    logic          ic_read, ic_write, dc_read, dc_write;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [DW-1:0] ic_wdata, dc_wdata;
    logic [DW-1:0] ic_rdata, dc_rdata;
    logic          ic_ready, dc_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr),
        .ic_wdata(ic_wdata), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: who currently owns memory and what it asked for.
    bit          m_busy  = 1'b0;
    bit          m_owner = 1'b0;   // 0 = I-cache, 1 = D-cache
    bit          m_last  = 1'b0;
    bit [AW-1:0] m_addr  = '0;
    bit [DW-1:0] m_data  = '0;
    bit          m_we    = 1'b0;
    int          served_i = 0;
    int          served_d = 0;

    always @(posedge clk) begin
        if (!proc_reset_n) begin
            m_busy = 0; m_owner = 0; m_last = 0; m_addr = '0; m_data = '0; m_we = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (m_owner) served_d++; else served_i++;
            end
        end else begin
            bit want_i, want_d, take_d;
            want_i = ic_read | ic_write;
            want_d = dc_read | dc_write;
            if (want_i || want_d) begin
                // Round-robin: on contention, the one not served last wins.
                take_d  = (want_i && want_d) ? !m_last : want_d;
                m_busy  = 1;
                m_owner = take_d;
                m_last  = take_d;
                m_addr  = take_d ? dc_addr  : ic_addr;
                m_data  = take_d ? dc_wdata : ic_wdata;
                m_we    = take_d ? dc_write : ic_write;
            end
        end
    end

    // Compare every cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            bit pending, e_rd, e_wr, e_ir, e_dr;
            pending = m_busy && !mem_ready;
            e_rd = pending && !m_we;
            e_wr = pending &&  m_we;
            e_ir = m_busy && !m_owner && mem_ready;
            e_dr = m_busy &&  m_owner && mem_ready;
            chk("mdl_mem_read",  DW'(mem_read),  DW'(e_rd));
            chk("mdl_mem_write", DW'(mem_write), DW'(e_wr));
            chk("mdl_mem_addr",  DW'(mem_addr),  DW'(m_addr));
            chk("mdl_mem_wdata", mem_wdata,      m_data);
            chk("mdl_ic_ready",  DW'(ic_ready),  DW'(e_ir));
            chk("mdl_dc_ready",  DW'(dc_ready),  DW'(e_dr));
            if (e_ir) chk("mdl_ic_rdata", ic_rdata, mem_rdata);
            if (e_dr) chk("mdl_dc_rdata", dc_rdata, mem_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one tick after the grant edge: hold off lat cycles, then complete.
    task automatic serve(input string tag, input int lat, input logic [DW-1:0] rd,
                         input bit is_d, input logic [AW-1:0] eaddr, input bit ewe);
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_addr"},   DW'(mem_addr),  DW'(eaddr));
            chk({tag, "_strobe"}, DW'({mem_write, mem_read}), DW'(ewe ? 2'b10 : 2'b01));
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        chk({tag, "_ic_ready"}, DW'(ic_ready), DW'(!is_d));
        chk({tag, "_dc_ready"}, DW'(dc_ready), DW'(is_d));
        chk({tag, "_strobe_drop"}, DW'({mem_write, mem_read}), DW'(2'b00));
        if (is_d) chk({tag, "_dc_rdata"}, dc_rdata, rd);
        else      chk({tag, "_ic_rdata"}, ic_rdata, rd);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        proc_reset_n = 1'b0;
        step();
        step();
        proc_reset_n = 1'b1;
    endtask

    localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] WD_D   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    initial begin
        proc_reset_n = 1'b0;
        ic_read = 0; ic_write = 0; dc_read = 0; dc_write = 0;
        ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0;
        mem_rdata = '0; mem_ready = 0;

        step();
        chk_en = 1'b1;
        do_reset();
        chk("rst_outputs", DW'({mem_read, mem_write, ic_ready, dc_ready}), DW'(4'b0));
        chk("rst_mem_addr", DW'(mem_addr), DW'(28'h0));
        chk("rst_mem_wdata", mem_wdata, '0);

        // I-cache read; address changes mid-grant must not leak through.
        ic_read = 1; ic_addr = 28'h0000010;
        step();
        chk("t1_read_next_cycle", DW'(mem_read), DW'(1'b1));
        chk("t1_addr", DW'(mem_addr), DW'(28'h0000010));
        ic_addr = 28'h0000020;
        step();
        chk("t4_addr_held", DW'(mem_addr), DW'(28'h0000010));
        step();
        serve("t1", 0, PAT_A5, 1'b0, 28'h0000010, 1'b0);
        ic_read = 0;
        chk("t1_idle_no_strobe", DW'({mem_read, mem_write}), DW'(2'b00));
        chk("t1_idle_addr_hold", DW'(mem_addr), DW'(28'h0000010));
        step();

        // D-cache write-back.
        dc_write = 1; dc_addr = 28'h0000123; dc_wdata = WD_D;
        step();
        chk("t2_wdata", mem_wdata, WD_D);
        serve("t2", 3, '0, 1'b1, 28'h0000123, 1'b1);
        dc_write = 0;
        step();

        // Read+write together: write dominates.
        dc_read = 1; dc_write = 1; dc_addr = 28'h0000200; dc_wdata = 128'hDEAD;
        step();
        chk("t5_write_dominates", DW'({mem_write, mem_read}), DW'(2'b10));
        serve("t5", 1, '0, 1'b1, 28'h0000200, 1'b1);
        dc_read = 0; dc_write = 0;
        step();

        // Round-robin after reset: D first, then alternating while both held.
        do_reset();
        ic_read = 1; ic_addr = 28'h0000040;
        dc_read = 1; dc_addr = 28'h0000080;
        step();
        chk("t3_first_d", DW'(mem_addr), DW'(28'h0000080));
        serve("t3a", 1, 128'h1, 1'b1, 28'h0000080, 1'b0);
        chk("t3_idle_gap", DW'(mem_read), DW'(1'b0));
        step();
        chk("t3_then_i", DW'(mem_addr), DW'(28'h0000040));
        serve("t3b", 2, 128'h2, 1'b0, 28'h0000040, 1'b0);
        step();
        chk("t3_then_d", DW'(mem_addr), DW'(28'h0000080));
        serve("t3c", 0, 128'h3, 1'b1, 28'h0000080, 1'b0);
        step();
        chk("t3_then_i2", DW'(mem_addr), DW'(28'h0000040));
        serve("t3d", 1, 128'h4, 1'b0, 28'h0000040, 1'b0);
        ic_read = 0; dc_read = 0;
        step();
        chk("served_i_count", DW'(served_i), DW'(3));
        chk("served_d_count", DW'(served_d), DW'(4));

        // Reset during a D grant abandons it with no ready pulse.
        dc_read = 1; dc_addr = 28'h0000300;
        step();
        chk("t6_granted", DW'(mem_read), DW'(1'b1));
        proc_reset_n = 0;
        dc_read = 0;
        step();
        proc_reset_n = 1;
        chk("t6_after_rst", DW'({mem_read, dc_ready, ic_ready}), DW'(3'b000));
        mem_ready = 1; mem_rdata = PAT_A5;
        #1;
        chk("t6_no_ready", DW'({ic_ready, dc_ready}), DW'(2'b00));
        step();
        mem_ready = 0;
        step();
        chk("t6_still_idle", DW'({mem_read, mem_write}), DW'(2'b00));

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache. Merges their two 128-bit block-level memory ports onto the single shared memory port.
- Grants one client at a time. Latches that client's request and forwards the memory handshake back to it.
- Both arbitrated clients must present the same protocol, including the D-cache:
  - the client asserts read or write and holds it until ready;
  - the client drops the request in the same cycle ready is seen.
- Arbitration is round-robin between the two clients.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, block data width.

Ports:
- clk  in  1  system clock, rising edge
- proc_reset_n  in  1  reset, synchronous, active-low
- ic_read  in  1  I-cache block read request
- ic_write  in  1  I-cache block write-back request
- ic_addr  in  ADDR_W  I-cache block address
- ic_wdata  in  DATA_W  I-cache write-back data
- ic_rdata  out  DATA_W  read data to I-cache
- ic_ready  out  1  I-cache transaction complete
- dc_read  in  1  D-cache block read request
- dc_write  in  1  D-cache write-back request
- dc_addr  in  ADDR_W  D-cache block address
- dc_wdata  in  DATA_W  D-cache write-back data
- dc_rdata  out  DATA_W  read data to D-cache
- dc_ready  out  1  D-cache transaction complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory transaction complete

Behaviour:
- States: IDLE, GNT_I, GNT_D. Internal registers:
  - req_addr, req_wdata, req_we;
  - last_gnt (0=I, 1=D).
- Reset (proc_reset_n=0 at a clock edge):
  - state=IDLE, last_gnt=0, req_addr=0, req_wdata=0, req_we=0.
  - Outputs then read: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ic_ready=0, dc_ready=0.
  - Reset mid-transaction abandons the grant with no ready pulse. The memory is reset by the same signal.
- IDLE:
  - A client is requesting when its read|write is 1.
  - Only one client requesting: grant it.
  - Both requesting: grant the client that is not last_gnt. After reset, D wins first.
  - On grant:
    - latch addr and wdata;
    - req_we = write (write dominates if read and write are both 1);
    - set last_gnt;
    - go to GNT_I or GNT_D next cycle.
  - No request: stay in IDLE. mem_ready is ignored in IDLE.
- GNT_x:
  - mem_addr=req_addr, mem_wdata=req_wdata.
  - mem_write = req_we & ~mem_ready.
  - mem_read = ~req_we & ~mem_ready.
  - Client inputs are ignored while granted; the latched copy is authoritative.
  - When mem_ready=1: x_ready=1 in that same cycle (combinational) and next state = IDLE.
  - Otherwise stay in GNT_x; waiting is unbounded.
- Outside GNT states: mem_read=mem_write=0. mem_addr and mem_wdata hold the last latched values.
- ic_rdata = dc_rdata = mem_rdata (pass-through). Data is valid only while the matching ready is 1.
- ic_ready and dc_ready are never 1 simultaneously. Each is 1 for exactly one cycle per transaction.
- Latency: request seen in cycle N → mem strobe asserted in N+1. mem_ready in cycle M → client ready in M. The next grant is decided in M+1 (IDLE) and its strobe appears in M+2.
- A write-back followed by a refill from the same cache becomes two separate grants. The other client may be granted in between under round-robin.
- Request held while the other client is served: the request is served at the next IDLE. It is guaranteed within one intervening transaction, so there is no starvation.

Test Plan:
- Reset, then ic_read=1, ic_addr=28'h0000010 held: cycle+1 mem_read=1, mem_addr=28'h0000010. Memory returns mem_ready with mem_rdata=128'hA5..A5 after 3 cycles → ic_ready=1 for one cycle, ic_rdata=128'hA5..A5, dc_ready stays 0.
- dc_write=1, dc_addr=28'h0000123, dc_wdata=128'h1111_2222_3333_4444_5555_6666_7777_8888: mem_write=1 with that addr and data until mem_ready. Then dc_ready pulses once and mem_write drops in the same cycle.
- After reset, ic_read and dc_read raised in the same cycle → D granted first (mem_addr=dc_addr). After dc_ready, I is granted. Both held again → D, then I, alternating.
- While GNT_I, change ic_addr from 28'h10 to 28'h20 → mem_addr stays 28'h10 until mem_ready.
- dc_read and dc_write both 1 → mem_write=1, mem_read=0.
- Deassert proc_reset_n during GNT_D before mem_ready → next cycle state IDLE, mem_read=0, dc_ready=0. mem_ready pulsed afterwards in IDLE → no ready output.
